serial_add_sub: RTL
===================

Name: serial_add_sub

Overview:
- Bit-serial WIDTH-bit adder/subtractor, LSB first.
- Built around one full_add_sub_1bit instance. The block feeds it one bit pair per clock and keeps the carry/borrow in a flip-flop between bits.
- Sits directly upstream of the 1-bit cell and turns it into a multi-bit datapath unit with a start/done handshake.
- Trades latency (WIDTH cycles) for area (one 1-bit cell).

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- m  input  1  mode, captured with start: 0 = add, 1 = subtract (a - b)
- a  input  WIDTH  operand A, captured with start
- b  input  WIDTH  operand B, captured with start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse: result/cout valid
- result  output  WIDTH  sum or difference
- cout  output  1  final carry (add) or final borrow (sub)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0:
  - state=IDLE
  - busy=0, done=0, result=0, cout=0
  - internal shift registers, bit counter and carry flop all cleared
  - reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a, b, m into shift regs; clear carry/borrow flop; counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each edge: apply a_sh[0], b_sh[0], carry flop and m_reg to the 1-bit cell.
  - Shift the cell's sum into the result shift reg from the MSB side.
  - Load the cell's cout into the carry flop.
  - Shift a_sh and b_sh right; increment counter.
  - On the edge processing bit WIDTH-1: go to DONE.
  - start is ignored in RUN.
  - m/a/b pins are don't-care after capture.
- DONE:
  - Lasts one cycle.
  - result and cout registers load on the edge entering DONE and hold until the next DONE entry or reset.
  - Next edge: start=1 captures new operands and goes to RUN (back-to-back); otherwise go to IDLE.
- Outputs are registered (Moore): busy=1 exactly in RUN; done=1 exactly in DONE.
- Latency: start sampled at edge 0 -> busy=1 for edges 0..WIDTH; done=1 between edge WIDTH and WIDTH+1.
  - Throughput: one operation per WIDTH+1 cycles.
- Arithmetic:
  - add: {cout,result} = a + b, initial carry 0.
  - sub: result = (a - b) mod 2^WIDTH; cout = 1 iff a < b unsigned; initial borrow 0.
- Counter width is $clog2(WIDTH) bits. It must not wrap before DONE for any WIDTH >= 2.

Optional Feature:
- Macro: SERIAL_ADD_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0, loaded on DONE entry alongside result.
  - Signed two's-complement overflow:
    - add: ovf = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB])
    - sub: ovf = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB])
  - Operand MSBs are captured at start.
- Undefined: ovf port and its logic absent; all other behaviour identical.

Test Plan (WIDTH=8):
- Add, m=0, a=8'h35, b=8'h4A, start one cycle -> busy=1 for 8 cycles; done one cycle later with result=8'h7F, cout=0.
- Add with carry out: a=8'hFF, b=8'h01 -> result=8'h00, cout=1.
- Subtract, m=1:
  - a=8'h50, b=8'h30 -> result=8'h20, cout=0.
  - Then a=8'h30, b=8'h50 -> result=8'hE0, cout=1.
- start re-pulsed with new a/b/m mid-RUN -> ignored; original result produced; done exactly once.
- Back-to-back and reset:
  - start held high through DONE -> second operation begins with no IDLE cycle.
  - Separately, rst_n=0 at bit 4 -> all outputs 0 immediately; no done; next start produces a correct result.
- With SERIAL_ADD_SUB_OVF_EN:
  - add 8'h7F+8'h01 -> result=8'h80, ovf=1.
  - sub 8'h80-8'h01 -> result=8'h7F, ovf=1.
  - add 8'h10+8'h20 -> ovf=0.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/result bundle for the bit-serial adder/subtractor.
//   start, m, a, b      : request (mode and operands captured with start)
//   busy, done          : status (busy while bits are processed, done one-cycle pulse)
//   result, cout        : sum/difference and final carry/borrow
//   ovf                 : signed overflow, present only with SERIAL_ADD_SUB_OVF_EN
// Modports: master drives the request, slave (the datapath) drives status/result.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf;

  modport master (output start, m, a, b, input busy, done, result, cout, ovf);
  modport slave  (input start, m, a, b, output busy, done, result, cout, ovf);
`else
  modport master (output start, m, a, b, input busy, done, result, cout);
  modport slave  (input start, m, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, LSB first, built around
// a single full_add_sub_1bit cell. One bit pair is processed per clock; the
// carry/borrow lives in a flop between bits. Latency WIDTH+1 cycles per op.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_add_sub_if.slave (start/m/a/b in; busy/done/result/cout out)
// Optional: define SERIAL_ADD_SUB_OVF_EN to add bus.ovf, the signed
// two's-complement overflow flag, loaded on DONE entry alongside result.

// 1-bit full adder / full subtractor. m_i=0: a+b+c, m_i=1: a-b-c (c is borrow).
module full_add_sub_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic m_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = m_i ? ((~a_i & b_i) | (~(a_i ^ b_i) & c_i))
                   : ((a_i & b_i) | ((a_i ^ b_i) & c_i));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_sub_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only WIDTH-1 bits are stored: the final bit goes straight into result_q.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] res_full;
  logic             last_bit;

  full_add_sub_1bit u_cell (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .m_i (m_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  // New sum bit enters from the MSB side; on the last bit this is the full result.
  assign res_full = {cell_s, res_sh_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          m_d     = bus.m;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_OVF_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = res_full[WIDTH-1:1];
        carry_d  = cell_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = res_full;
          cout_d   = cell_c;
`ifdef SERIAL_ADD_SUB_OVF_EN
          // Add overflows when like-signed operands give an unlike-signed result;
          // subtract when unlike-signed operands do.
          ovf_d = (m_q ? (a_msb_q ^ b_msb_q) : ~(a_msb_q ^ b_msb_q))
                  & (cell_s ^ a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      m_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif
endmodule
